multicycle_ctrl_hs: RTL
=======================

MULTICYCLE_CTRL_HS -- requirements
Module: multicycle_ctrl_hs

Interface
REQ-001 Parameter ALUCTR_W, default 4, SHALL set ALUctr width; legal values are 4 or more, with codes zero-extended.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the max wait cycles for mem_ack; the value 0 disables the timeout.
REQ-003 Parameter BYTE_EN, default 1, SHALL be 1 to make lb/sb legal and 0 to make them illegal opcodes.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port instruction, input, 32 bits: the current IR contents; opcode is [31:26] and funct is [5:0].
REQ-007 Port zero, input, 1 bit: the ALU zero flag, sampled in EXE.
REQ-008 Port mem_ack, input, 1 bit: memory completion for the current mem_req.
REQ-009 Port mem_req, output, 1 bit: memory access request.
REQ-010 Ports IRWr, PCWr, RegWr and MemWr are outputs, 1 bit each: the write enables.
REQ-011 Ports RegDst, ALUSrc, MemtoReg, j_sel, jal_sel, lb_sel and sb_sel are outputs, 1 bit each: the datapath selects.
REQ-012 Ports ExtOp and nPC_sel are outputs, 2 bits each; ALUctr is an output of ALUCTR_W bits.
REQ-013 Port state, output, 3 bits: the current FSM state.
REQ-014 Port err, output, 1 bit: sticky error flag.

Function
REQ-015 States SHALL be encoded IF=000, RF=001, EXE=010, MEM=011, WB=100 and ERR=111.
REQ-016 IF SHALL assert mem_req; on mem_ack it SHALL pulse IRWr for one cycle and go to RF.
REQ-017 RF SHALL decode the instruction:
- illegal opcode/funct goes to ERR;
- jal goes to WB;
- everything else goes to EXE.
REQ-018 The legal instruction set is addu, subu, slt, jr, addi, addiu, ori, lui, lw, sw, beq, j and jal, plus lb and sb when BYTE_EN=1.
REQ-019 EXE transitions SHALL be:
- beq, j and jr go to IF with PCWr=1 for that cycle;
- lw, sw, lb and sb go to MEM;
- all others go to WB.
REQ-020 MEM SHALL assert mem_req, and SHALL assert MemWr for sw/sb throughout MEM.
REQ-021 MEM on mem_ack SHALL go to WB for lw/lb, or to IF with PCWr=1 for sw/sb.
REQ-022 WB SHALL assert RegWr=1 and PCWr=1 for one cycle, then go to IF.
REQ-023 ERR SHALL hold err=1 with all enables and mem_req at 0, and SHALL leave ERR only on rst.
REQ-024 A wait counter SHALL clear on entry to IF/MEM and increment each cycle without mem_ack.
REQ-025 When TIMEOUT is nonzero and the counter equals TIMEOUT with no mem_ack, the FSM SHALL go to ERR on the next edge.
REQ-026 mem_ack in the same cycle the counter reaches TIMEOUT SHALL win: the FSM advances normally.
REQ-027 mem_ack outside IF/MEM SHALL be ignored.
REQ-028 The counter SHALL saturate; it SHALL NOT wrap.
REQ-029 Select outputs SHALL be combinational from opcode/funct, given as {ALUSrc, MemtoReg, RegDst, j_sel, jal_sel, lb_sel, sb_sel, ExtOp, ALUctr}:
- addu: 0010000, 00, ADD
- subu: 0010000, 00, SUB
- slt: 0010000, 00, SLT
- addi/addiu: 1000000, 01, ADD
- ori: 1000000, 00, OR
- lui: 1000000, 10, OR
- lw: 1100000, 01, ADD
- sw: 1000000, 01, ADD
- lb: 1100010, 01, ADD
- sb: 1000001, 01, ADD
- beq: 0000000, 01, SUB
- j: 0001000, 00, ADD
- jal: 0001100, 00, ADD
- jr: 0000000, 00, ADD
REQ-030 ALU codes SHALL be ADD=0, SUB=1, OR=2, AND=3 and SLT=4.
REQ-031 nPC_sel SHALL encode 00 = +4, 01 = branch, 10 = j/jal and 11 = jr.
REQ-032 beq SHALL drive nPC_sel=01 only when zero=1, and 00 otherwise.
REQ-033 Write enables (IRWr, PCWr, RegWr, MemWr) and mem_req SHALL be 0 in any state/opcode combination not listed above.
REQ-034 Select outputs SHALL be 0 for illegal opcodes.
REQ-035 The opcode/funct values are j=02, jal=03, beq=04, addi=08, addiu=09, ori=0D, lui=0F, lb=20, lw=23, sb=28 and sw=2B (hex).
REQ-036 The R-type funct values, for opcode 00, are jr=08, addu=21, subu=23 and slt=2A (hex).

Reset
REQ-037 rst=1 at a clock edge SHALL set state=IF, wait counter=0 and err=0, from any state including mid-MEM and ERR.
REQ-038 While rst=1, all write enables SHALL be 0 and mem_req SHALL be 0.
REQ-039 The first cycle after rst deasserts SHALL be IF with mem_req=1.

Verification
REQ-040 addu with mem_ack in the first IF cycle -> states IF,RF,EXE,WB,IF; IRWr=1 in IF; RegWr=1, PCWr=1 in WB only; ALUctr=0, RegDst=1.
REQ-041 lw with mem_ack delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, MemWr=0; then WB with MemtoReg=1, RegWr=1.
REQ-042 sw/sb with BYTE_EN=1 -> MemWr=1 across MEM; PCWr=1 on the ack cycle; next state IF. sb gives sb_sel=1.
REQ-043 beq with zero=1 then zero=0 -> EXE is the last state, PCWr=1 in both cases; nPC_sel=01 then 00.
REQ-044 TIMEOUT=3 with no ack in IF -> ERR after the 4th IF cycle with err=1. An ack in exactly that cycle -> RF instead.
REQ-045 Opcode 3F, or lb with BYTE_EN=0 -> RF then ERR. rst pulsed during ERR or mid-MEM -> IF, err=0, no MemWr after reset.

Source files
------------

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle MIPS-subset controller with a memory handshake (mem_req/mem_ack),
// a saturating wait counter with optional timeout, and a sticky error state.
//
// state | meaning
// ------+---------------------------------------------------------------
// IF    | fetch: request memory, load IR on mem_ack
// RF    | decode/register read: illegal -> ERR, jal -> WB, else EXE
// EXE   | execute: branches/jumps update PC and refetch, loads/stores -> MEM
// MEM   | data access: hold request until mem_ack (stores write throughout)
// WB    | register write-back and PC update
// ERR   | sticky fault: all enables low, exit only through rst
module multicycle_ctrl_hs #(
  parameter int ALUCTR_W = 4,
  parameter int TIMEOUT  = 15,
  parameter int BYTE_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                IRWr,
  output logic                PCWr,
  output logic                RegWr,
  output logic                MemWr,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                j_sel,
  output logic                jal_sel,
  output logic                lb_sel,
  output logic                sb_sel,
  output logic [1:0]          ExtOp,
  output logic [1:0]          nPC_sel,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [2:0]          state,
  output logic                err
);

  localparam logic [2:0] S_IF  = 3'b000;
  localparam logic [2:0] S_RF  = 3'b001;
  localparam logic [2:0] S_EXE = 3'b010;
  localparam logic [2:0] S_MEM = 3'b011;
  localparam logic [2:0] S_WB  = 3'b100;
  localparam logic [2:0] S_ERR = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign unused_instr = ^instruction[25:6];

  logic       legal;
  logic       is_load;
  logic       is_store;
  logic       is_beq;
  logic       is_j;
  logic       is_jal;
  logic       is_jr;
  logic [6:0] sel;
  logic [1:0] ext;
  logic [2:0] alu;

  // sel packs {ALUSrc, MemtoReg, RegDst, j_sel, jal_sel, lb_sel, sb_sel}
  always_comb begin
    legal    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_beq   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    sel      = 7'b0000000;
    ext      = 2'b00;
    alu      = ALU_ADD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21: begin legal = 1'b1; sel = 7'b0010000; alu = ALU_ADD; end
          6'h23: begin legal = 1'b1; sel = 7'b0010000; alu = ALU_SUB; end
          6'h2A: begin legal = 1'b1; sel = 7'b0010000; alu = ALU_SLT; end
          6'h08: begin legal = 1'b1; is_jr = 1'b1; end
          default: ;
        endcase
      end
      6'h02: begin legal = 1'b1; is_j = 1'b1; sel = 7'b0001000; end
      6'h03: begin legal = 1'b1; is_jal = 1'b1; sel = 7'b0001100; end
      6'h04: begin legal = 1'b1; is_beq = 1'b1; ext = 2'b01; alu = ALU_SUB; end
      6'h08, 6'h09: begin legal = 1'b1; sel = 7'b1000000; ext = 2'b01; end
      6'h0D: begin legal = 1'b1; sel = 7'b1000000; alu = ALU_OR; end
      6'h0F: begin legal = 1'b1; sel = 7'b1000000; ext = 2'b10; alu = ALU_OR; end
      6'h23: begin legal = 1'b1; is_load = 1'b1; sel = 7'b1100000; ext = 2'b01; end
      6'h2B: begin legal = 1'b1; is_store = 1'b1; sel = 7'b1000000; ext = 2'b01; end
      6'h20: begin
        if (BYTE_EN != 0) begin
          legal = 1'b1; is_load = 1'b1; sel = 7'b1100010; ext = 2'b01;
        end
      end
      6'h28: begin
        if (BYTE_EN != 0) begin
          legal = 1'b1; is_store = 1'b1; sel = 7'b1000001; ext = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign {ALUSrc, MemtoReg, RegDst, j_sel, jal_sel, lb_sel, sb_sel} = sel;
  assign ExtOp  = ext;
  assign ALUctr = ALUCTR_W'(alu);

  always_comb begin
    nPC_sel = 2'b00;
    if (is_beq)              nPC_sel = zero ? 2'b01 : 2'b00;
    else if (is_j || is_jal) nPC_sel = 2'b10;
    else if (is_jr)          nPC_sel = 2'b11;
  end

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             pc_flow;

  assign pc_flow   = is_beq || is_j || is_jr;
  // an ack arriving in the terminal cycle takes priority over the timeout
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_VAL) && !mem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (mem_ack)        state_d = S_RF;
        else if (timed_out) state_d = S_ERR;
      end
      S_RF: begin
        if (!legal)      state_d = S_ERR;
        else if (is_jal) state_d = S_WB;
        else             state_d = S_EXE;
      end
      S_EXE: begin
        if (pc_flow)                  state_d = S_IF;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ack)        state_d = is_load ? S_WB : S_IF;
        else if (timed_out) state_d = S_ERR;
      end
      S_WB:    state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if ((state_q == S_IF || state_q == S_MEM) && !mem_ack && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign err     = (state_q == S_ERR);

  assign mem_req = !rst && (state_q == S_IF || state_q == S_MEM);
  assign IRWr    = !rst && (state_q == S_IF) && mem_ack;
  assign RegWr   = !rst && (state_q == S_WB);
  assign MemWr   = !rst && (state_q == S_MEM) && is_store;
  assign PCWr    = !rst && (((state_q == S_EXE) && pc_flow) ||
                            ((state_q == S_MEM) && is_store && mem_ack) ||
                            (state_q == S_WB));

endmodule
